// File: rtl/micro_mult_seq_ctrl.sv
// Shift-and-add sequential multiplier controller.
// One WIDTH-bit adder reused over WIDTH RUN cycles; result held until ack.
module micro_mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_sum;
  logic               w_last;

  // ACC's top bit only ever receives the zero shifted in, so it is
  // not stored; the adder carry lands in ACC[WIDTH-1] after the shift.
  assign w_sum  = {1'b0, r_acc}
                + (r_m[0] ? {1'b0, r_a} : '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else if (ena) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_m     <= op_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_sum[WIDTH:1];
          r_m   <= {w_sum[0], r_m[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= {w_sum, r_m[WIDTH-1:1]};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            r_done <= 1'b0;
            if (start) begin
              r_a     <= op_a;
              r_m     <= op_b;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
